ninjin_layer_seq: RTL
=====================

// Module: ninjin_layer_seq
// PURPOSE
// - Multi-layer sequencer ahead of the renkon/gobou core select.
// - Holds up to LAYERS layer descriptors written over the AXI-lite register bank.
// - On start, runs each layer in order: drives which/addr/size config, pulses req,
//   waits for core ack, then swaps ping-pong image buffers.
// - Removes per-layer CPU polling; CPU writes descriptors, starts, then waits for done.
// PARAMETERS
// - LAYERS   8   descriptor slots (power of 2)
// - LWIDTH   16  layer-size field width (matches core total_out/total_in/...)
// - IMGSIZE  12  image memory address width
// PORTS
// - clk          in   1        system clock
// - xrst         in   1        reset, asynchronous, active-low
// - cfg_we       in   1        descriptor write strobe
// - cfg_layer    in   log2(L)  descriptor slot
// - cfg_field    in   3        0:which 1:total_out 2:total_in 3:img_size 4:fil_size 5:pool_size
// - cfg_data     in   LWIDTH   field value (which uses bit 0)
// - num_layers   in   log2(L)+1  layers to run, sampled at start
// - base_a       in   IMGSIZE  buffer A base (layer 0 input)
// - base_b       in   IMGSIZE  buffer B base (layer 0 output)
// - start        in   1        one-cycle start pulse
// - abort        in   1        stop after current layer completes
// - ack          in   1        core completion (from renkon/gobou ack mux)
// - busy         out  1        sequence in progress
// - done         out  1        one-cycle pulse at sequence end (normal or abort)
// - cur_layer    out  log2(L)  layer being executed
// - which        out  1        0 renkon, 1 gobou
// - req          out  1        one-cycle core request pulse
// - input_addr / output_addr   out IMGSIZE  current layer buffers
// - total_out, total_in, img_size, fil_size, pool_size   out LWIDTH  current layer config
// BEHAVIOUR
// - Reset: all outputs 0; state IDLE; descriptors cleared to 0.
// - States: IDLE -> LOAD -> ISSUE -> WAIT -> NEXT -> (LOAD | FIN) -> IDLE.
// - IDLE:
//   - start with num_layers>0: latch num_layers, layer=0, in=base_a, out=base_b; go LOAD.
//   - start with num_layers==0: done pulse next cycle, no req, busy stays 0.
// - LOAD:
//   - Descriptor read (1-cycle sync RAM).
//   - Config outputs register one cycle later and stay stable through WAIT.
// - ISSUE: req=1 for exactly one cycle. Config is valid >=1 cycle before req.
// - WAIT:
//   - Holds until rising edge of ack (registered ack_d; edge = ack & ~ack_d).
//   - An ack level already high at ISSUE is not a completion.
// - NEXT:
//   - layer+1; swap input_addr/output_addr.
//   - If layer+1==num_layers or abort latched: go FIN, else LOAD.
// - FIN: done=1 one cycle, busy=0 next cycle.
// - busy=1 from the cycle after start through the FIN cycle.
// - Latency: start->first req = 3 cycles; ack edge->next req = 4 cycles.
// - Boundary and conflict rules:
//   - start while busy: ignored.
//   - cfg_we while busy: ignored; slot contents unchanged.
//   - cfg_we and start same cycle in IDLE: write takes effect, start uses the new value.
//   - abort: sticky until FIN. Never drops an outstanding req/ack pair. abort in IDLE: ignored.
//   - Layer counter wraps never; num_layers>LAYERS is clamped to LAYERS.
//   - xrst mid-sequence: immediate IDLE, req=0; the core is reset by the same xrst.
// CONFIGURATION
// - NINJIN_SEQ_PERF_EN defined: adds out perf_cycles[31:0].
//   - Counts cycles from ISSUE to ack edge of the last completed layer.
//   - Cleared at start; saturates at all-ones.
// - NINJIN_SEQ_PERF_EN undefined: port and counter absent; no other behaviour change.
// STRUCTURE
// - ninjin_seq_pkg: seq_state_t enum, layer_desc_t struct (which + five LWIDTH fields),
//   field index localparams.
// - Sub-module ninjin_seq_desc_mem: LAYERS x layer_desc_t, 1 write port (field-granular),
//   1 sync read port.
// - Top holds FSM, counters, ping-pong address registers.
// TESTING
// - Two layers:
//   - Setup: slot0 {which=0,in=1,out=16}, slot1 {which=1,...}, base_a=0x000, base_b=0x400,
//     num_layers=2, start.
//   - L0: req with which=0, in=0x000, out=0x400.
//   - L1: req with which=1, in=0x400, out=0x000.
//   - End: one done pulse.
// - num_layers=0, start -> done next cycle, req never asserted, busy 0 throughout.
// - Stuck ack: ack held 1 before start -> first layer waits for fall then rise; exactly one
//   req per layer.
// - abort during layer 1 of 4 -> layer 1 completes, no req for layer 2, done, cur_layer=1.
// - start and cfg_we while busy -> ignored (descriptor readback unchanged, no restart);
//   xrst mid-WAIT -> all outputs 0 immediately.
// - NINJIN_SEQ_PERF_EN: ack exactly 100 cycles after req on final layer -> perf_cycles=100.

Source files
------------

// File: rtl/ninjin_seq_pkg.sv
// rtl/ninjin_seq_pkg.sv - shared types for the ninjin layer sequencer
// FSM state enum, layer descriptor struct, and descriptor field indices.
package ninjin_seq_pkg;

  localparam int LWIDTH_DEF = 16;

  localparam logic [2:0] FLD_WHICH     = 3'd0;
  localparam logic [2:0] FLD_TOTAL_OUT = 3'd1;
  localparam logic [2:0] FLD_TOTAL_IN  = 3'd2;
  localparam logic [2:0] FLD_IMG_SIZE  = 3'd3;
  localparam logic [2:0] FLD_FIL_SIZE  = 3'd4;
  localparam logic [2:0] FLD_POOL_SIZE = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ISSUE,
    S_WAIT,
    S_NEXT,
    S_FIN
  } seq_state_t;

  typedef struct packed {
    logic                  which;
    logic [LWIDTH_DEF-1:0] total_out;
    logic [LWIDTH_DEF-1:0] total_in;
    logic [LWIDTH_DEF-1:0] img_size;
    logic [LWIDTH_DEF-1:0] fil_size;
    logic [LWIDTH_DEF-1:0] pool_size;
  } layer_desc_t;

  // Field-granular update; unknown field indices leave the descriptor untouched.
  function automatic layer_desc_t write_field(layer_desc_t d, logic [2:0] f,
                                              logic [LWIDTH_DEF-1:0] v);
    layer_desc_t r;
    r = d;
    case (f)
      FLD_WHICH:     r.which     = v[0];
      FLD_TOTAL_OUT: r.total_out = v;
      FLD_TOTAL_IN:  r.total_in  = v;
      FLD_IMG_SIZE:  r.img_size  = v;
      FLD_FIL_SIZE:  r.fil_size  = v;
      FLD_POOL_SIZE: r.pool_size = v;
      default:       r = d;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ninjin_seq_desc_mem.sv
// rtl/ninjin_seq_desc_mem.sv - layer descriptor store
// One field-granular write port, one synchronous read port (registered address).
module ninjin_seq_desc_mem
  import ninjin_seq_pkg::*;
#(
  parameter int LAYERS = 8
) (
  input  logic                        clk,
  input  logic                        xrst,
  input  logic                        we,
  input  logic [$clog2(LAYERS)-1:0]   waddr,
  input  logic [2:0]                  wfield,
  input  logic [LWIDTH_DEF-1:0]       wdata,
  input  logic [$clog2(LAYERS)-1:0]   raddr,
  output layer_desc_t                 rdata
);

  layer_desc_t                 mem [LAYERS];
  logic [$clog2(LAYERS)-1:0]   raddr_q;

  // Registering the address (not the data) makes a same-cycle write visible to the next read.
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      for (int i = 0; i < LAYERS; i++) mem[i] <= '0;
      raddr_q <= '0;
    end else begin
      if (we) mem[waddr] <= write_field(mem[waddr], wfield, wdata);
      raddr_q <= raddr;
    end
  end

  assign rdata = mem[raddr_q];

endmodule

// File: rtl/ninjin_layer_seq.sv
// rtl/ninjin_layer_seq.sv - multi-layer sequencer ahead of the renkon/gobou core select
// Define NINJIN_SEQ_PERF_EN to add the perf_cycles output.
module ninjin_layer_seq
  import ninjin_seq_pkg::*;
#(
  parameter int LAYERS  = 8,
  parameter int LWIDTH  = LWIDTH_DEF,
  parameter int IMGSIZE = 12
) (
  input  logic                        clk,
  input  logic                        xrst,
  input  logic                        cfg_we,
  input  logic [$clog2(LAYERS)-1:0]   cfg_layer,
  input  logic [2:0]                  cfg_field,
  input  logic [LWIDTH-1:0]           cfg_data,
  input  logic [$clog2(LAYERS):0]     num_layers,
  input  logic [IMGSIZE-1:0]          base_a,
  input  logic [IMGSIZE-1:0]          base_b,
  input  logic                        start,
  input  logic                        abort,
  input  logic                        ack,
  output logic                        busy,
  output logic                        done,
  output logic [$clog2(LAYERS)-1:0]   cur_layer,
  output logic                        which,
  output logic                        req,
  output logic [IMGSIZE-1:0]          input_addr,
  output logic [IMGSIZE-1:0]          output_addr,
  output logic [LWIDTH-1:0]           total_out,
  output logic [LWIDTH-1:0]           total_in,
  output logic [LWIDTH-1:0]           img_size,
  output logic [LWIDTH-1:0]           fil_size,
  output logic [LWIDTH-1:0]           pool_size
`ifdef NINJIN_SEQ_PERF_EN
  ,
  output logic [31:0]                 perf_cycles
`endif
);

  localparam int LW = $clog2(LAYERS);
  localparam logic [LW:0] NUM_MAX = LAYERS[LW:0];

  seq_state_t    state, state_nxt;
  logic [LW-1:0] layer;
  logic [LW:0]   num_q;
  logic          abort_q;
  logic          ack_d;
  logic          zero_done;
  logic [LW-1:0] rd_addr;
  layer_desc_t   rd_desc;
  logic          start_go;
  logic          ack_edge;
  logic          last_layer;

  assign start_go   = start && (state == S_IDLE) && (num_layers != '0);
  assign ack_edge   = ack && !ack_d;
  assign last_layer = (({1'b0, layer} + 1'b1) == num_q) || abort_q || abort;
  assign cur_layer  = layer;

  ninjin_seq_desc_mem #(.LAYERS(LAYERS)) u_desc_mem (
    .clk    (clk),
    .xrst   (xrst),
    .we     (cfg_we && (state == S_IDLE)),
    .waddr  (cfg_layer),
    .wfield (cfg_field),
    .wdata  (cfg_data),
    .raddr  (rd_addr),
    .rdata  (rd_desc)
  );

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start_go) state_nxt = S_LOAD;
      S_LOAD:  state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:  if (ack_edge) state_nxt = S_NEXT;
      S_NEXT:  state_nxt = last_layer ? S_FIN : S_LOAD;
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // The read address leads LOAD by one cycle so config is settled a cycle before req.
  always_comb begin
    busy    = (state != S_IDLE);
    done    = (state == S_FIN) || zero_done;
    rd_addr = layer;
    case (state)
      S_IDLE:  rd_addr = '0;
      S_NEXT:  rd_addr = layer + 1'b1;
      default: rd_addr = layer;
    endcase
  end

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      req         <= 1'b0;
      ack_d       <= 1'b0;
      zero_done   <= 1'b0;
      abort_q     <= 1'b0;
      num_q       <= '0;
      layer       <= '0;
      input_addr  <= '0;
      output_addr <= '0;
      which       <= 1'b0;
      total_out   <= '0;
      total_in    <= '0;
      img_size    <= '0;
      fil_size    <= '0;
      pool_size   <= '0;
    end else begin
      req       <= (state == S_ISSUE);
      ack_d     <= ack;
      zero_done <= start && (state == S_IDLE) && (num_layers == '0);

      if (start_go || state == S_FIN) abort_q <= 1'b0;
      else if (state != S_IDLE && abort) abort_q <= 1'b1;

      if (start_go) begin
        num_q       <= (num_layers > NUM_MAX) ? NUM_MAX : num_layers;
        layer       <= '0;
        input_addr  <= base_a;
        output_addr <= base_b;
      end

      if (state == S_LOAD) begin
        which     <= rd_desc.which;
        total_out <= rd_desc.total_out;
        total_in  <= rd_desc.total_in;
        img_size  <= rd_desc.img_size;
        fil_size  <= rd_desc.fil_size;
        pool_size <= rd_desc.pool_size;
      end

      // The final layer keeps its index so cur_layer reports the last layer run.
      if (state == S_NEXT) begin
        input_addr  <= output_addr;
        output_addr <= input_addr;
        if (!last_layer) layer <= layer + 1'b1;
      end
    end
  end

`ifdef NINJIN_SEQ_PERF_EN
  logic [31:0] perf_cnt;

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      perf_cnt    <= '0;
      perf_cycles <= '0;
    end else if (start && state == S_IDLE) begin
      perf_cnt    <= '0;
      perf_cycles <= '0;
    end else if (state == S_ISSUE) begin
      perf_cnt <= '0;
    end else if (state == S_WAIT) begin
      if (ack_edge)               perf_cycles <= perf_cnt;
      else if (perf_cnt != '1)    perf_cnt    <= perf_cnt + 1'b1;
    end
  end
`endif

endmodule
